stream_demux_1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer: the inverse of the datapath 2-to-1 mux.
- Routes each input beat, per its Selector, into one of two per-channel FIFOs. Each FIFO drives an independent valid/ready output channel.
- Used where one producer (e.g. memory/IO return path) feeds two consumers. Decouples backpressure per channel and preserves per-channel order.

---
 rtl/stream_demux_1to2.sv | 71 +++++++
 tb/tb_stream_demux_1to2.sv | 117 +++++++++++
 2 files changed

// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: routes each input beat by Selector into one of two
// per-channel FIFOs, each drained through its own valid/ready output channel.
module stream_demux_1to2 #(
  parameter int NBits     = 32,
  parameter int FifoDepth = 4,
  parameter int CntW      = $clog2(FifoDepth) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Selector,
  input  logic [NBits-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [NBits-1:0] Out0_Data,
  output logic             Out0_Valid,
  input  logic             Out0_Ready,
  output logic [NBits-1:0] Out1_Data,
  output logic             Out1_Valid,
  input  logic             Out1_Ready,
  output logic [CntW-1:0]  Out0_Count,
  output logic [CntW-1:0]  Out1_Count
);
  localparam int PW = $clog2(FifoDepth);
  localparam logic [CntW-1:0] FULL = CntW'(FifoDepth);
  logic [NBits-1:0] mem_q [2][FifoDepth];
  logic [NBits-1:0] mem_d [2][FifoDepth];
  logic [PW-1:0]    wp_q [2], wp_d [2], rp_q [2], rp_d [2];
  logic [CntW-1:0]  cnt_q [2], cnt_d [2];
  logic [1:0]       push, pop, out_ready;
  assign out_ready  = {Out1_Ready, Out0_Ready};
  assign Out0_Data  = mem_q[0][rp_q[0]];
  assign Out1_Data  = mem_q[1][rp_q[1]];
  assign Out0_Valid = cnt_q[0] != '0;
  assign Out1_Valid = cnt_q[1] != '0;
  assign Out0_Count = cnt_q[0];
  assign Out1_Count = cnt_q[1];
  // Ready looks only at the selected count, so a full FIFO never accepts even while popping.
  always_comb begin
    mem_d    = mem_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    In_Ready = Selector ? cnt_q[1] != FULL : cnt_q[0] != FULL;
    push     = {In_Valid & In_Ready & Selector, In_Valid & In_Ready & ~Selector};
    pop      = {(cnt_q[1] != '0) & out_ready[1], (cnt_q[0] != '0) & out_ready[0]};
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_d[i][wp_q[i]] = In_Data;
        wp_d[i]           = wp_q[i] + PW'(1);
      end
      rp_d[i]  = pop[i] ? rp_q[i] + PW'(1) : rp_q[i];
      cnt_d[i] = (push[i] & ~pop[i]) ? cnt_q[i] + CntW'(1) :
                 (pop[i] & ~push[i]) ? cnt_q[i] - CntW'(1) : cnt_q[i];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < FifoDepth; j++) mem_q[i][j] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: directed plus random traffic checked against two queue models.
module tb_stream_demux_1to2;
  localparam int NB = 32, DEPTH = 4, CW = $clog2(DEPTH) + 1;
  logic          clk = 0, reset = 0, Selector = 0, In_Valid = 0, In_Ready;
  logic [NB-1:0] In_Data = '0, Out0_Data, Out1_Data;
  logic          Out0_Valid, Out1_Valid, Out0_Ready = 0, Out1_Ready = 0;
  logic [CW-1:0] Out0_Count, Out1_Count;
  int            n_asserts = 0, n_fails = 0;
  logic [NB-1:0] q0[$], q1[$];

  stream_demux_1to2 #(.NBits(NB), .FifoDepth(DEPTH)) dut (
    .clk(clk), .reset(reset), .Selector(Selector), .In_Data(In_Data),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Out0_Data(Out0_Data), .Out0_Valid(Out0_Valid), .Out0_Ready(Out0_Ready),
    .Out1_Data(Out1_Data), .Out1_Valid(Out1_Valid), .Out1_Ready(Out1_Ready),
    .Out0_Count(Out0_Count), .Out1_Count(Out1_Count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks outputs against the queues, then advances the model across one edge.
  task automatic cycle();
    bit rdy, pop0, pop1;
    #1;
    rdy = Selector ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
    if (In_Valid) chk("sel_known", 32'(!$isunknown(Selector)), 1);
    chk("in_ready", 32'(In_Ready), 32'(rdy));
    chk("out0_valid", 32'(Out0_Valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(Out1_Valid), 32'(q1.size() != 0));
    chk("out0_count", 32'(Out0_Count), q0.size());
    chk("out1_count", 32'(Out1_Count), q1.size());
    if (q0.size() != 0) chk("out0_data", Out0_Data, q0[0]);
    if (q1.size() != 0) chk("out1_data", Out1_Data, q1[0]);
    pop0 = q0.size() != 0 && Out0_Ready;
    pop1 = q1.size() != 0 && Out1_Ready;
    @(posedge clk);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (In_Valid && rdy) begin
      if (Selector) q1.push_back(In_Data);
      else q0.push_back(In_Data);
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input logic [NB-1:0] d, input bit r0, input bit r1);
    In_Valid = v; Selector = s; In_Data = d; Out0_Ready = r0; Out1_Ready = r1;
    cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1;
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Three beats to channel 0 held back, then drained.
    drive(1, 0, 32'hA1, 0, 0);
    drive(1, 0, 32'hA2, 0, 0);
    drive(1, 0, 32'hA3, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("a_count", 32'(Out0_Count), 3);
    chk("a_head", Out0_Data, 32'hA1);
    repeat (4) drive(0, 0, 0, 1, 0);
    chk("a_empty", 32'(Out0_Valid), 0);
    // Fill channel 1, then exercise full-channel behaviour.
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h10 + i, 0, 0);
    chk("f_count", 32'(Out1_Count), 4);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 32'h14, 0, 0);
    drive(1, 1, 32'h14, 0, 0);
    chk("f_held", 32'(Out1_Count), 4);
    drive(1, 1, 32'h14, 0, 1);
    chk("f_popnopush", 32'(Out1_Count), 3);
    drive(1, 1, 32'h15, 0, 1);
    chk("f_pushpop", 32'(Out1_Count), 3);
    repeat (4) drive(0, 0, 0, 0, 1);
    // Interleaved, then a wrapping stream on channel 0.
    for (int i = 1; i <= 4; i++) drive(1, i % 2 == 0, NB'(i), 1, 1);
    for (int i = 0; i < 12; i++) drive(1, 0, 32'hC0 + i, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    repeat (6) drive(0, 0, 0, 1, 1);
    // Asynchronous reset with beats in flight.
    drive(1, 0, 32'h70, 0, 0);
    drive(1, 0, 32'h71, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h80 + i, 0, 0);
    In_Valid = 0;
    chk("r_pre0", 32'(Out0_Count), 2);
    chk("r_pre1", 32'(Out1_Count), 3);
    #2 reset = 0;
    #1;
    chk("r_cnt0", 32'(Out0_Count), 0);
    chk("r_cnt1", 32'(Out1_Count), 0);
    chk("r_vld0", 32'(Out0_Valid), 0);
    chk("r_vld1", 32'(Out1_Valid), 0);
    q0.delete(); q1.delete();
    @(posedge clk);
    #1 reset = 1;
    drive(1, 0, 32'h55, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("r_first", Out0_Data, 32'h55);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
